cpu_mode_ctrl: RTL

CPU_MODE_CTRL -- requirements
Module: cpu_mode_ctrl

---
 rtl/cpu_pkg.sv | 15 +
 rtl/cpu_mode_ctrl_step_qual.sv | 77 +++++++
 rtl/cpu_mode_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared mode encodings for the mode controller and the control unit.
// cpustate carries these values unchanged.
package cpu_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_IN    = 2'b01;
  localparam logic [1:0] ST_CHECK = 2'b10;
  localparam logic [1:0] ST_RUN   = 2'b11;

  // True for the two modes that drive the loader address counter.
  function automatic logic is_loader_mode(input logic [1:0] st);
    return (st == ST_IN) || (st == ST_CHECK);
  endfunction

endpackage

// File: rtl/cpu_mode_ctrl_step_qual.sv
// Operator step qualifier: one registered pulse per press.
// STEP_DEBOUNCE_EN adds a 2-flop synchronizer and a DB_CYCLES stable filter.
module step_qual #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  output logic pulse
);

`ifdef STEP_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // The filtered level only flips after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    pulse_d = stable_q & ~stable_prev_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
      pulse_q       <= 1'b0;
    end else begin
      sync1_q       <= step;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
      pulse_q       <= pulse_d;
    end
  end
`else
  logic        prev_q;
  logic        pulse_q, pulse_d;
  logic [31:0] unused_db_cycles;

  assign unused_db_cycles = 32'(DB_CYCLES);

  always_comb begin
    pulse_d = step & ~prev_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= step;
      pulse_q <= pulse_d;
    end
  end
`endif

  assign pulse = pulse_q;

endmodule

// File: rtl/cpu_mode_ctrl.sv
// Front-panel mode controller: IDLE/IN/CHECK/RUN, byte loader and run reset.
// Optional STEP_DEBOUNCE_EN selects the debounced step qualifier.
module cpu_mode_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode_sel,
  input  logic              step,
  input  logic [7:0]        din,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        cpustate,
  output logic              run_rst_n,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [7:0]        ld_wdata,
  output logic              ld_we,
  output logic              ld_re,
  output logic [7:0]        disp_data,
  output logic              ld_wrap
);

  logic [1:0]        state_q, state_d;
  logic              run_rst_n_q, run_rst_n_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [7:0]        ld_wdata_q, ld_wdata_d;
  logic              ld_we_q, ld_we_d;
  logic              ld_re_q, ld_re_d;
  logic              rd_pend_q, rd_pend_d;
  logic [7:0]        disp_data_q, disp_data_d;
  logic              ld_wrap_q, ld_wrap_d;

  logic step_pulse;
  logic chg, entry, busy, accept, capture, advance;

  step_qual #(
    .DB_CYCLES(DB_CYCLES)
  ) u_step_qual (
    .clk  (clk),
    .reset(reset),
    .step (step),
    .pulse(step_pulse)
  );

  // A read stays outstanding from its strobe until the data cycle; a mode change drops it.
  always_comb begin
    chg     = (mode_sel != state_q);
    entry   = chg && is_loader_mode(mode_sel);
    busy    = ld_we_q | ld_re_q | rd_pend_q;
    accept  = step_pulse & ~chg & ~busy & is_loader_mode(state_q);
    capture = rd_pend_q & ~chg;
    advance = ld_we_q | capture;

    state_d     = mode_sel;
    run_rst_n_d = (state_q == ST_RUN) && !chg;
    ld_addr_d   = ld_addr_q;
    ld_wrap_d   = ld_wrap_q;
    ld_wdata_d  = ld_wdata_q;
    ld_we_d     = 1'b0;
    ld_re_d     = 1'b0;
    rd_pend_d   = ld_re_q & ~chg;
    disp_data_d = disp_data_q;

    if (capture) begin
      disp_data_d = mem_rdata;
    end else begin
      disp_data_d = disp_data_q;
    end

    if (entry) begin
      ld_addr_d = '0;
      ld_wrap_d = 1'b0;
    end else if (advance) begin
      ld_addr_d = ld_addr_q + 1'b1;
      ld_wrap_d = ld_wrap_q | (&ld_addr_q);
    end else begin
      ld_addr_d = ld_addr_q;
      ld_wrap_d = ld_wrap_q;
    end

    if (accept) begin
      case (state_q)
        ST_IN: begin
          ld_we_d    = 1'b1;
          ld_wdata_d = din;
        end
        ST_CHECK: begin
          ld_re_d = 1'b1;
        end
        default: begin
          ld_we_d = 1'b0;
          ld_re_d = 1'b0;
        end
      endcase
    end else begin
      ld_we_d = 1'b0;
      ld_re_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      run_rst_n_q <= 1'b0;
      ld_addr_q   <= '0;
      ld_wdata_q  <= 8'h00;
      ld_we_q     <= 1'b0;
      ld_re_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      disp_data_q <= 8'h00;
      ld_wrap_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_rst_n_q <= run_rst_n_d;
      ld_addr_q   <= ld_addr_d;
      ld_wdata_q  <= ld_wdata_d;
      ld_we_q     <= ld_we_d;
      ld_re_q     <= ld_re_d;
      rd_pend_q   <= rd_pend_d;
      disp_data_q <= disp_data_d;
      ld_wrap_q   <= ld_wrap_d;
    end
  end

  assign cpustate  = state_q;
  assign run_rst_n = run_rst_n_q;
  assign ld_addr   = ld_addr_q;
  assign ld_wdata  = ld_wdata_q;
  assign ld_we     = ld_we_q;
  assign ld_re     = ld_re_q;
  assign disp_data = disp_data_q;
  assign ld_wrap   = ld_wrap_q;

endmodule
